// File: rtl/dtack_gen.sv
// DTACK/BERR generator for the CPU bus.
// Decodes memmap chip selects into per-region wait states and a bus timeout.
module dtack_gen #(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned ROM_WAIT = 3,
    parameter int unsigned IO_WAIT  = 4,
    parameter int unsigned GFX_WAIT = 2,
    parameter int unsigned REG_WAIT = 0,
    parameter int unsigned TIMEOUT  = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_as,
    input  logic pas,
    input  logic csunmap,
    input  logic csram1,
    input  logic csram2,
    input  logic csrom,
    input  logic csio,
    input  logic csgfx,
    input  logic csctrl,
    input  logic cspgtbl,
    output logic dtack,
    output logic berr,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_FAULT
    } state_t;

    localparam logic [7:0] RAM_W = 8'(RAM_WAIT);
    localparam logic [7:0] ROM_W = 8'(ROM_WAIT);
    localparam logic [7:0] IO_W  = 8'(IO_WAIT);
    localparam logic [7:0] GFX_W = 8'(GFX_WAIT);
    localparam logic [7:0] REG_W = 8'(REG_WAIT);
    localparam logic [7:0] TMO   = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] tmo_inc;
    logic       dtack_q, dtack_d;
    logic       berr_q, berr_d;
    logic       busy_q, busy_d;
    logic       armed_q, armed_d;
    logic [7:0] cs_vec;
    logic       cs_one;
    logic [7:0] sel_wait;

    assign cs_vec = {csunmap, csram1, csram2, csrom,
                     csio, csgfx, csctrl, cspgtbl};
    assign cs_one = $onehot(cs_vec);

    // Wait count of the selected region (only meaningful when cs_one)
    always_comb begin
        sel_wait = REG_W;
        case (1'b1)
            csram1:  sel_wait = RAM_W;
            csram2:  sel_wait = RAM_W;
            csrom:   sel_wait = ROM_W;
            csio:    sel_wait = IO_W;
            csgfx:   sel_wait = GFX_W;
            default: sel_wait = REG_W;
        endcase
    end

    // Next-state, counters and registered outputs
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        tmo_inc = (tmo_q == 8'hFF) ? 8'hFF : tmo_q + 8'd1;
        armed_d = !cpu_as;
        if (!cpu_as) begin
            state_d = S_IDLE;
            wait_d  = 8'd0;
            tmo_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        state_d = S_DECODE;
                        wait_d  = 8'd0;
                        tmo_d   = 8'd0;
                    end
                end
                S_DECODE: begin
                    if (pas) begin
                        if (cs_one) begin
                            wait_d  = sel_wait;
                            state_d = (sel_wait == 8'd0) ? S_ACK : S_WAIT;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else begin
                        tmo_d = tmo_inc;
                        if (tmo_inc >= TMO)
                            state_d = S_FAULT;
                    end
                end
                S_WAIT: begin
                    if (wait_q <= 8'd1) begin
                        wait_d  = 8'd0;
                        state_d = S_ACK;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
                S_ACK:   state_d = S_ACK;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
        dtack_d = (state_d == S_ACK);
        berr_d  = (state_d == S_FAULT);
        busy_d  = (state_d != S_IDLE);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
            tmo_q   <= 8'd0;
            dtack_q <= 1'b0;
            berr_q  <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
        end
    end

    assign dtack = dtack_q;
    assign berr  = berr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dtack_gen.sv
// Directed bench for dtack_gen.
// Checks wait latency, faults, timeout, abort and reset behaviour.
module tb_dtack_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_as = 1'b0;
    logic pas = 1'b0;
    logic csunmap = 1'b0, csram1 = 1'b0, csram2 = 1'b0, csrom = 1'b0;
    logic csio = 1'b0, csgfx = 1'b0, csctrl = 1'b0, cspgtbl = 1'b0;
    logic dtack, berr, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dtack_gen dut (
        .clk(clk), .reset(reset), .cpu_as(cpu_as), .pas(pas),
        .csunmap(csunmap), .csram1(csram1), .csram2(csram2),
        .csrom(csrom), .csio(csio), .csgfx(csgfx),
        .csctrl(csctrl), .cspgtbl(cspgtbl),
        .dtack(dtack), .berr(berr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // outputs packed as {dtack, berr, busy}
    function automatic logic [7:0] outs();
        return {5'd0, dtack, berr, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cs_clear();
        {csunmap, csram1, csram2, csrom, csio, csgfx, csctrl, cspgtbl} = '0;
    endtask

    task automatic end_cycle(input string tag);
        cpu_as = 1'b0;
        pas = 1'b0;
        cs_clear();
        tick();
        chk(tag, outs(), 8'b000);
    endtask

    initial begin
        // reset
        tick();
        chk("reset", outs(), 8'b000);
        reset = 1'b0;
        tick();
        chk("idle", outs(), 8'b000);

        // ROM: dtack three edges after pas sample
        cpu_as = 1'b1;
        tick();
        chk("rom_decode", outs(), 8'b001);
        pas = 1'b1;
        csrom = 1'b1;
        tick();
        chk("rom_k0", outs(), 8'b001);
        csrom = 1'b0;
        csctrl = 1'b1;
        pas = 1'b0;
        tick();
        chk("rom_k1", outs(), 8'b001);
        tick();
        chk("rom_k2", outs(), 8'b001);
        tick();
        chk("rom_k3", outs(), 8'b101);
        tick();
        chk("rom_hold", outs(), 8'b101);
        end_cycle("rom_end");

        // csctrl: zero wait
        cpu_as = 1'b1;
        tick();
        pas = 1'b1;
        csctrl = 1'b1;
        tick();
        chk("ctrl_ack", outs(), 8'b101);
        end_cycle("ctrl_end");

        // unmapped: no chip select
        cpu_as = 1'b1;
        tick();
        pas = 1'b1;
        tick();
        chk("unmap_berr", outs(), 8'b011);
        tick();
        chk("unmap_hold", outs(), 8'b011);
        end_cycle("unmap_end");

        // two chip selects
        cpu_as = 1'b1;
        tick();
        pas = 1'b1;
        csram1 = 1'b1;
        csrom = 1'b1;
        tick();
        chk("multi_berr", outs(), 8'b011);
        end_cycle("multi_end");

        // timeout with pas held low
        cpu_as = 1'b1;
        tick();
        for (int i = 0; i < 62; i++) tick();
        chk("tmo_62", outs(), 8'b001);
        tick();
        chk("tmo_63", outs(), 8'b011);
        pas = 1'b1;
        csrom = 1'b1;
        tick();
        chk("tmo_late_pas", outs(), 8'b011);
        end_cycle("tmo_end");

        // csio aborted during wait
        cpu_as = 1'b1;
        tick();
        pas = 1'b1;
        csio = 1'b1;
        tick();
        tick();
        tick();
        chk("io_wait", outs(), 8'b001);
        end_cycle("io_abort");
        for (int i = 0; i < 6; i++) tick();
        chk("io_no_late", outs(), 8'b000);

        // reset during RAM wait
        cpu_as = 1'b1;
        tick();
        pas = 1'b1;
        csram1 = 1'b1;
        tick();
        chk("ram_wait", outs(), 8'b001);
        reset = 1'b1;
        tick();
        chk("ram_reset", outs(), 8'b000);
        reset = 1'b0;
        tick();
        tick();
        chk("rst_noarm", outs(), 8'b000);
        cpu_as = 1'b0;
        pas = 1'b0;
        cs_clear();
        tick();
        cpu_as = 1'b1;
        tick();
        chk("ram2_decode", outs(), 8'b001);
        pas = 1'b1;
        csram1 = 1'b1;
        tick();
        chk("ram2_k0", outs(), 8'b001);
        tick();
        chk("ram2_k1", outs(), 8'b101);
        end_cycle("ram2_end");

        // GFX two waits, abort in DECODE
        cpu_as = 1'b1;
        tick();
        pas = 1'b1;
        csgfx = 1'b1;
        tick();
        tick();
        chk("gfx_k1", outs(), 8'b001);
        tick();
        chk("gfx_k2", outs(), 8'b101);
        end_cycle("gfx_end");
        cpu_as = 1'b1;
        tick();
        end_cycle("dec_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dtack_gen.md
DTACK_GEN -- requirements
Module: dtack_gen

Interface
REQ-001 SHALL provide parameter RAM_WAIT, default 1, wait states for csram1/csram2 cycles.
REQ-002 SHALL provide parameter ROM_WAIT, default 3, wait states for csrom cycles.
REQ-003 SHALL provide parameter IO_WAIT, default 4, wait states for csio cycles.
REQ-004 SHALL provide parameter GFX_WAIT, default 2, wait states for csgfx cycles.
REQ-005 SHALL provide parameter REG_WAIT, default 0, wait states for csctrl, cspgtbl and csunmap cycles.
REQ-006 SHALL provide parameter TIMEOUT, default 63, max cycles from cycle start to a pas sample before bus error; range 1..255.
REQ-007 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port cpu_as, input, 1, high while the CPU bus cycle is in progress.
REQ-010 SHALL have port pas, input, 1, physical address strobe from memmap; high = chip selects valid.
REQ-011 SHALL have ports csunmap, csram1, csram2, csrom, csio, csgfx, csctrl, cspgtbl, input, 1 each, chip selects from memmap.
REQ-012 SHALL have port dtack, output, 1, active-high data transfer acknowledge.
REQ-013 SHALL have port berr, output, 1, active-high bus error.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, DECODE, WAIT, ACK, FAULT; dtack and berr registered, never high together.
REQ-016 IDLE: cpu_as=1 -> DECODE, timeout counter cleared to 0.
REQ-017 DECODE: timeout counter increments each cycle pas=0; reaching TIMEOUT -> FAULT.
REQ-018 DECODE with pas=1: exactly one cs high -> load that region's wait W; W=0 -> ACK, else WAIT.
REQ-019 DECODE with pas=1: zero cs high (undefined memory) or more than one cs high -> FAULT.
REQ-020 WAIT: W decrements per cycle; transition to ACK at the edge where it reaches 0.
REQ-021 Latency: with pas first sampled high at edge k, dtack SHALL be high starting at edge k+W.
REQ-022 ACK holds dtack=1, FAULT holds berr=1, until cpu_as sampled 0.
REQ-023 cpu_as sampled 0 in any state -> IDLE; dtack, berr, busy low from that edge; pending wait count discarded, no late dtack.
REQ-024 After IDLE re-entry, a new cycle SHALL NOT start until cpu_as is sampled 0 at least one edge (no back-to-back without strobe gap).
REQ-025 Chip selects SHALL be sampled only at the DECODE edge where pas=1; later changes to cs lines or pas SHALL NOT alter the cycle.
REQ-026 Wait and timeout counters SHALL be 8 bits, saturating; no wrap-around.

Reset
REQ-027 reset=1 at any edge SHALL force IDLE, dtack=0, berr=0, busy=0, counters 0, overriding all other inputs, including mid-WAIT/ACK.
REQ-028 After reset deasserts with cpu_as already 1, a cycle SHALL start only after cpu_as returns 0 then 1.

Verification
REQ-029 cpu_as=1, pas=1 with csrom=1 at edge k -> dtack high at edge k+3, held until cpu_as=0, then low next edge.
REQ-030 cpu_as=1, pas=1 with csctrl=1 -> dtack high at the same edge pas sampled; berr stays 0.
REQ-031 cpu_as=1, pas=1, all cs=0 (address 0x04) -> berr high next edge, dtack never high.
REQ-032 cpu_as=1, pas held 0 for 63 cycles -> berr high; pas rising afterwards ignored.
REQ-033 csio cycle, cpu_as dropped after 2 wait cycles -> IDLE, dtack never asserts.
REQ-034 reset pulsed during a csram1 WAIT -> all outputs 0 next edge; next full cycle acks normally with W=1.
